// File: rtl/core_mem_arbiter_pkg.sv
// Shared encodings for the core/memory arbiter: FSM states, access owners
// and the access-kind constant used on the *_we_re lines.
package core_mem_arbiter_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] owner_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_I    = 2'd1;
    localparam owner_t OWN_D    = 2'd2;

    localparam logic WE_RE_WRITE = 1'b1;

    // Next streak value after a data grant, saturating at the limit.
    function automatic logic [7:0] streak_after_data(input logic [7:0] streak,
                                                     input logic [7:0] limit,
                                                     input logic       i_waiting);
        logic [7:0] nxt;
        if (!i_waiting) begin
            nxt = 8'd0;
        end else if (streak >= limit) begin
            nxt = limit;
        end else begin
            nxt = streak + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundle of the instruction port, data port and memory-side signals.
// slave = arbiter view, master = core + memory view.
interface core_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              i_req;
    logic              i_we_re;
    logic [3:0]        i_mask;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_valid;

    logic              d_req;
    logic              d_we_re;
    logic [3:0]        d_mask;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;

    logic              mem_request;
    logic              mem_we_re;
    logic [3:0]        mem_mask;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport slave (
        input  i_req, i_we_re, i_mask, i_addr,
        output i_rdata, i_valid,
        input  d_req, d_we_re, d_mask, d_addr, d_wdata,
        output d_rdata, d_valid,
        output mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata,
        input  mem_rdata, mem_valid
    );

    modport master (
        output i_req, i_we_re, i_mask, i_addr,
        input  i_rdata, i_valid,
        output d_req, d_we_re, d_mask, d_addr, d_wdata,
        input  d_rdata, d_valid,
        input  mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata,
        output mem_rdata, mem_valid
    );

endinterface

// File: rtl/core_mem_arbiter_arb_priority_sel.sv
// Grant pick for an idle arbiter: data wins unless the instruction port has
// already been passed over DATA_STREAK_MAX times in a row.
module arb_priority_sel
    import core_mem_arbiter_pkg::*;
#(
    parameter int STREAK_W        = 3,
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic                i_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output owner_t              grant
);

    logic streak_full_s;

    assign streak_full_s = (streak == STREAK_W'(DATA_STREAK_MAX));

    // Priority decision between the two request lines.
    always_comb begin
        grant = OWN_NONE;
        if (d_req && !(i_req && streak_full_s)) begin
            grant = OWN_D;
        end else if (i_req) begin
            grant = OWN_I;
        end else begin
            grant = OWN_NONE;
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-ported memory
// with an IDLE/BUSY/RESP handshake, data priority, starvation guard and timeout.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int DATA_STREAK_MAX = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic               clk,
    input  logic               rst,
    core_mem_arbiter_if.slave  bus,
    output logic               timeout_err
);

    localparam int STREAK_W = $clog2(DATA_STREAK_MAX + 1);
    localparam int TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state_r,       state_nxt_s;
    owner_t              owner_r,       owner_nxt_s;
    owner_t              grant_s;
    logic [STREAK_W-1:0] streak_r,      streak_nxt_s;
    logic [TIMER_W-1:0]  timer_r,       timer_nxt_s;

    logic                mem_request_r, mem_request_nxt_s;
    logic                mem_we_re_r,   mem_we_re_nxt_s;
    logic [3:0]          mem_mask_r,    mem_mask_nxt_s;
    logic [ADDR_W-1:0]   mem_addr_r,    mem_addr_nxt_s;
    logic [DATA_W-1:0]   mem_wdata_r,   mem_wdata_nxt_s;

    logic [DATA_W-1:0]   i_rdata_r,     i_rdata_nxt_s;
    logic                i_valid_r,     i_valid_nxt_s;
    logic [DATA_W-1:0]   d_rdata_r,     d_rdata_nxt_s;
    logic                d_valid_r,     d_valid_nxt_s;
    logic                timeout_err_r, timeout_err_nxt_s;

    logic [STREAK_W-1:0] streak_data_s;

    arb_priority_sel #(
        .STREAK_W        (STREAK_W),
        .DATA_STREAK_MAX (DATA_STREAK_MAX)
    ) u_sel (
        .i_req  (bus.i_req),
        .d_req  (bus.d_req),
        .streak (streak_r),
        .grant  (grant_s)
    );

    assign streak_data_s = STREAK_W'(streak_after_data(8'(streak_r),
                                                       8'(DATA_STREAK_MAX),
                                                       bus.i_req));

    // Next-state logic for the access FSM and all output registers.
    always_comb begin
        state_nxt_s       = state_r;
        owner_nxt_s       = owner_r;
        streak_nxt_s      = streak_r;
        timer_nxt_s       = timer_r;
        mem_request_nxt_s = mem_request_r;
        mem_we_re_nxt_s   = mem_we_re_r;
        mem_mask_nxt_s    = mem_mask_r;
        mem_addr_nxt_s    = mem_addr_r;
        mem_wdata_nxt_s   = mem_wdata_r;
        i_rdata_nxt_s     = i_rdata_r;
        d_rdata_nxt_s     = d_rdata_r;
        i_valid_nxt_s     = 1'b0;
        d_valid_nxt_s     = 1'b0;
        timeout_err_nxt_s = timeout_err_r;

        case (state_r)
            ST_IDLE: begin
                timer_nxt_s = TIMER_W'(0);
                if (grant_s == OWN_D) begin
                    owner_nxt_s       = OWN_D;
                    state_nxt_s       = ST_BUSY;
                    streak_nxt_s      = streak_data_s;
                    timer_nxt_s       = TIMER_W'(1);
                    mem_request_nxt_s = 1'b1;
                    mem_we_re_nxt_s   = bus.d_we_re;
                    mem_mask_nxt_s    = bus.d_mask;
                    mem_addr_nxt_s    = bus.d_addr;
                    mem_wdata_nxt_s   = bus.d_wdata;
                end else if (grant_s == OWN_I) begin
                    owner_nxt_s       = OWN_I;
                    state_nxt_s       = ST_BUSY;
                    streak_nxt_s      = STREAK_W'(0);
                    timer_nxt_s       = TIMER_W'(1);
                    mem_request_nxt_s = 1'b1;
                    mem_we_re_nxt_s   = bus.i_we_re;
                    mem_mask_nxt_s    = bus.i_mask;
                    mem_addr_nxt_s    = bus.i_addr;
                    mem_wdata_nxt_s   = DATA_W'(0);
                end else begin
                    owner_nxt_s = OWN_NONE;
                end
            end

            // timer_r holds the index of the current BUSY cycle, starting at 1
            ST_BUSY: begin
                if (bus.mem_valid) begin
                    mem_request_nxt_s = 1'b0;
                    state_nxt_s       = ST_RESP;
                    timer_nxt_s       = TIMER_W'(0);
                    case (owner_r)
                        OWN_I: begin
                            i_rdata_nxt_s = bus.mem_rdata;
                            i_valid_nxt_s = 1'b1;
                        end
                        OWN_D: begin
                            d_rdata_nxt_s = bus.mem_rdata;
                            d_valid_nxt_s = 1'b1;
                        end
                        default: begin
                            state_nxt_s = ST_RESP;
                        end
                    endcase
                end else if (timer_r >= TIMER_W'(TIMEOUT_CYCLES)) begin
                    mem_request_nxt_s = 1'b0;
                    state_nxt_s       = ST_RESP;
                    timer_nxt_s       = TIMER_W'(0);
                    timeout_err_nxt_s = 1'b1;
                    case (owner_r)
                        OWN_I: begin
                            i_rdata_nxt_s = DATA_W'(0);
                            i_valid_nxt_s = 1'b1;
                        end
                        OWN_D: begin
                            d_rdata_nxt_s = DATA_W'(0);
                            d_valid_nxt_s = 1'b1;
                        end
                        default: begin
                            state_nxt_s = ST_RESP;
                        end
                    endcase
                end else begin
                    timer_nxt_s = timer_r + TIMER_W'(1);
                end
            end

            ST_RESP: begin
                state_nxt_s = ST_IDLE;
                owner_nxt_s = OWN_NONE;
                timer_nxt_s = TIMER_W'(0);
            end

            default: begin
                state_nxt_s       = ST_IDLE;
                owner_nxt_s       = OWN_NONE;
                timer_nxt_s       = TIMER_W'(0);
                mem_request_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            owner_r       <= OWN_NONE;
            streak_r      <= STREAK_W'(0);
            timer_r       <= TIMER_W'(0);
            mem_request_r <= 1'b0;
            mem_we_re_r   <= 1'b0;
            mem_mask_r    <= 4'b0000;
            mem_addr_r    <= ADDR_W'(0);
            mem_wdata_r   <= DATA_W'(0);
            i_rdata_r     <= DATA_W'(0);
            i_valid_r     <= 1'b0;
            d_rdata_r     <= DATA_W'(0);
            d_valid_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            owner_r       <= owner_nxt_s;
            streak_r      <= streak_nxt_s;
            timer_r       <= timer_nxt_s;
            mem_request_r <= mem_request_nxt_s;
            mem_we_re_r   <= mem_we_re_nxt_s;
            mem_mask_r    <= mem_mask_nxt_s;
            mem_addr_r    <= mem_addr_nxt_s;
            mem_wdata_r   <= mem_wdata_nxt_s;
            i_rdata_r     <= i_rdata_nxt_s;
            i_valid_r     <= i_valid_nxt_s;
            d_rdata_r     <= d_rdata_nxt_s;
            d_valid_r     <= d_valid_nxt_s;
            timeout_err_r <= timeout_err_nxt_s;
        end
    end

    assign bus.mem_request = mem_request_r;
    assign bus.mem_we_re   = mem_we_re_r;
    assign bus.mem_mask    = mem_mask_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.i_rdata     = i_rdata_r;
    assign bus.i_valid     = i_valid_r;
    assign bus.d_rdata     = d_rdata_r;
    assign bus.d_valid     = d_valid_r;
    assign timeout_err     = timeout_err_r;

endmodule
